// File: rtl/sa_skew_feeder.sv
// sa_skew_feeder: buffers an N-beat operand set and drives a systolic array's skewed edges
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   in_valid/ready  upstream handshake; one k-slice per beat
//   in_a_col        column k of A, element i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_b_row        row k of B, element j at [j*DATA_WIDTH +: DATA_WIDTH]
//   a_edge, b_edge  registered left/top edge operands, diagonally skewed and zero padded
//   busy            streaming or draining
//   done            one-cycle pulse once PE(N-1,N-1) holds its final sum
module sa_skew_feeder #(
    parameter int DATA_WIDTH = 10,
    parameter int N = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N*DATA_WIDTH-1:0] in_a_col,
    input  logic [N*DATA_WIDTH-1:0] in_b_row,
    output logic [N*DATA_WIDTH-1:0] a_edge,
    output logic [N*DATA_WIDTH-1:0] b_edge,
    output logic                    busy,
    output logic                    done
);
    localparam int W  = N * DATA_WIDTH;
    localparam int TW = $clog2(3 * N);
    localparam int CW = $clog2(N);
    typedef enum logic [1:0] {LOAD, STREAM, DRAIN} state_t;
    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [TW-1:0]       t_q, t_d;
    logic [N-1:0][W-1:0] a_col_q, a_col_d, b_row_q, b_row_d;
    logic [W-1:0]        a_edge_q, a_edge_d, b_edge_q, b_edge_d;
    logic                done_q, done_d;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        t_d     = t_q;
        a_col_d = a_col_q;
        b_row_d = b_row_q;
        done_d  = 1'b0;
        case (state_q)
            LOAD: if (in_valid) begin
                a_col_d[cnt_q] = in_a_col;
                b_row_d[cnt_q] = in_b_row;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    cnt_d   = '0;
                    t_d     = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                t_d = t_q + 1'b1;
                if (t_q == TW'(2 * N - 2)) state_d = DRAIN;
            end
            DRAIN: begin
                t_d = t_q + 1'b1;
                if (t_q == TW'(3 * N - 3)) begin
                    t_d     = '0;
                    done_d  = 1'b1;
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
        // edges are registered, so they are computed from the next cycle's t and buffer
        // contents; this lets the t=0 values appear right after the last load beat
        a_edge_d = '0;
        b_edge_d = '0;
        if (state_d == STREAM) begin
            for (int i = 0; i < N; i++) begin
                if (int'(t_d) >= i && int'(t_d) - i < N) begin
                    a_edge_d[i*DATA_WIDTH +: DATA_WIDTH] = a_col_d[CW'(int'(t_d) - i)][i*DATA_WIDTH +: DATA_WIDTH];
                    b_edge_d[i*DATA_WIDTH +: DATA_WIDTH] = b_row_d[CW'(int'(t_d) - i)][i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= LOAD;
            cnt_q    <= '0;
            t_q      <= '0;
            a_col_q  <= '0;
            b_row_q  <= '0;
            a_edge_q <= '0;
            b_edge_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            t_q      <= t_d;
            a_col_q  <= a_col_d;
            b_row_q  <= b_row_d;
            a_edge_q <= a_edge_d;
            b_edge_q <= b_edge_d;
            done_q   <= done_d;
        end
    end
    assign in_ready = state_q == LOAD;
    assign busy     = state_q != LOAD;
    assign done     = done_q;
    assign a_edge   = a_edge_q;
    assign b_edge   = b_edge_q;
endmodule

// File: tb/tb_sa_skew_feeder.sv
// tb_sa_skew_feeder: directed/random checks of the skew feeder against a matrix model and a PE grid
module tb_sa_skew_feeder;
    localparam int DW = 10;
    localparam int N  = 4;
    localparam int W  = N * DW;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a_col = '0;
    logic [W-1:0] in_b_row = '0;
    logic [W-1:0] a_edge, b_edge;
    logic         busy, done;
    int           n_cmp = 0;
    int           n_bad = 0;
    int           A[N][N];
    int           B[N][N];
    int           pa[N][N];
    int           pb[N][N];
    int           acc[N][N];
    int           ain[N][N];
    int           bin[N][N];
    logic         pe_clr = 1'b1;
    always #5 clk = ~clk;
    sa_skew_feeder #(.DATA_WIDTH(DW), .N(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a_col(in_a_col), .in_b_row(in_b_row), .a_edge(a_edge), .b_edge(b_edge),
        .busy(busy), .done(done)
    );
    function automatic int el(input logic [W-1:0] v, input int i);
        return int'($signed(v[i*DW +: DW]));
    endfunction
    // behavioural PE grid: acc += a*b, a moves right, b moves down, one hop per clock
    always_comb begin
        ain = '{default: 0};
        bin = '{default: 0};
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (j == 0) ain[i][j] = el(a_edge, i);
                else ain[i][j] = pa[i][j-1];
                if (i == 0) bin[i][j] = el(b_edge, j);
                else bin[i][j] = pb[i-1][j];
            end
        end
    end
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                pa[i][j]  <= pe_clr ? 0 : ain[i][j];
                pb[i][j]  <= pe_clr ? 0 : bin[i][j];
                acc[i][j] <= pe_clr ? 0 : acc[i][j] + ain[i][j] * bin[i][j];
            end
        end
    end
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask
    function automatic logic [W-1:0] exp_a(input int t);
        logic [W-1:0] v = '0;
        for (int i = 0; i < N; i++) if (t - i >= 0 && t - i < N) v[i*DW +: DW] = DW'(A[i][t-i]);
        return v;
    endfunction
    function automatic logic [W-1:0] exp_b(input int t);
        logic [W-1:0] v = '0;
        for (int j = 0; j < N; j++) if (t - j >= 0 && t - j < N) v[j*DW +: DW] = DW'(B[t-j][j]);
        return v;
    endfunction
    function automatic logic [W-1:0] col(input int k);
        logic [W-1:0] v = '0;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'(A[i][k]);
        return v;
    endfunction
    function automatic logic [W-1:0] row(input int k);
        logic [W-1:0] v = '0;
        for (int j = 0; j < N; j++) v[j*DW +: DW] = DW'(B[k][j]);
        return v;
    endfunction
    function automatic int cref(input int i, input int j);
        int s = 0;
        for (int k = 0; k < N; k++) s += A[i][k] * B[k][j];
        return s;
    endfunction
    function automatic logic [W-1:0] junk();
        return W'({$urandom, $urandom});
    endfunction
    task automatic fill(input bit directed);
        logic [DW-1:0] r;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                r = DW'($urandom);
                A[i][k] = directed ? 4 * i + k + 1 : int'($signed(r));
                r = DW'($urandom);
                B[i][k] = directed ? -(4 * i + k + 1) : int'($signed(r));
            end
        end
    endtask
    // called at a negedge in LOAD; returns at the negedge of STREAM t=0
    task automatic load(input logic [15:0] pat, input int plen);
        int k = 0;
        int c = 0;
        pe_clr = 1'b1;
        while (k < N) begin
            in_valid = (c < plen) ? pat[c] : 1'b1;
            in_a_col = in_valid ? col(k) : junk();
            in_b_row = in_valid ? row(k) : junk();
            chk("load_ready", 64'(in_ready), 64'(1));
            chk("load_busy", 64'(busy), 64'(0));
            chk("load_a", 64'(a_edge), 64'(0));
            chk("load_b", 64'(b_edge), 64'(0));
            @(negedge clk);
            if (in_valid) k++;
            c++;
        end
        in_valid = 1'b0;
        pe_clr = 1'b0;
    endtask
    // checks each STREAM/DRAIN cycle; stops early at stop_t, else ends at the done cycle
    task automatic stream(input bit hold, input int stop_t);
        for (int t = 0; t <= 3 * N - 3; t++) begin
            if (t == stop_t) return;
            in_valid = hold;
            in_a_col = junk();
            in_b_row = junk();
            chk($sformatf("a_t%0d", t), 64'(a_edge), 64'(exp_a(t)));
            chk($sformatf("b_t%0d", t), 64'(b_edge), 64'(exp_b(t)));
            chk("str_busy", 64'(busy), 64'(1));
            chk("str_ready", 64'(in_ready), 64'(0));
            chk("str_done", 64'(done), 64'(0));
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("done_pulse", 64'(done), 64'(1));
        chk("done_ready", 64'(in_ready), 64'(1));
        chk("done_busy", 64'(busy), 64'(0));
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                chk($sformatf("c%0d%0d", i, j), 64'(acc[i][j]), 64'(cref(i, j)));
    endtask
    initial begin
        in_valid = 1'b1;
        repeat (3) begin
            in_a_col = junk();
            in_b_row = junk();
            @(negedge clk);
            chk("rst_a", 64'(a_edge), 64'(0));
            chk("rst_b", 64'(b_edge), 64'(0));
            chk("rst_ready", 64'(in_ready), 64'(1));
            chk("rst_busy", 64'(busy), 64'(0));
            chk("rst_done", 64'(done), 64'(0));
        end
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_a", 64'(a_edge), 64'(0));
            chk("idle_busy", 64'(busy), 64'(0));
        end
        fill(1'b1);
        load(16'h0059, 7);
        stream(1'b0, -1);
        chk("c00_const", 64'(acc[0][0]), 64'(-90));
        chk("c33_const", 64'(acc[3][3]), 64'(-600));
        repeat (5) begin
            @(negedge clk);
            chk("post_done", 64'(done), 64'(0));
            chk("post_busy", 64'(busy), 64'(0));
        end
        fill(1'b0);
        load(16'h0, 0);
        stream(1'b1, -1);
        fill(1'b0);
        load(16'($urandom), 8);
        stream(1'b0, -1);
        fill(1'b0);
        load(16'h0, 0);
        stream(1'b0, 4);
        #2 rst = 1'b0;
        #1;
        chk("arst_a", 64'(a_edge), 64'(0));
        chk("arst_b", 64'(b_edge), 64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("ab_a", 64'(a_edge), 64'(0));
            chk("ab_b", 64'(b_edge), 64'(0));
            chk("ab_done", 64'(done), 64'(0));
            chk("ab_ready", 64'(in_ready), 64'(1));
        end
        fill(1'b0);
        load(16'($urandom), 6);
        stream(1'b1, -1);
        @(negedge clk);
        chk("final_done", 64'(done), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sa_skew_feeder.md
Name: sa_skew_feeder

Overview:
- Edge driver for an N x N systolic multiply array built from PE tiles. Each PE tile accumulates a*b and forwards a to the right and b downward.
- The feeder accepts matrix operands one k-slice per handshake beat and buffers a full N-beat operand set.
- It then drives the array's left edge (a) and top edge (b) with the diagonally skewed, zero-padded streams the PEs consume.
- It signals done once the last product has been accumulated in PE(N-1,N-1).

Parameters:
- DATA_WIDTH, 10: operand width, signed two's complement; must match the PE tile.
- N, 4: array dimension, which is also the inner dimension K; N >= 2.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  feeder can accept a beat.
- in_a_col  input  N*DATA_WIDTH  column k of A; element i = A[i][k] at bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_b_row  input  N*DATA_WIDTH  row k of B; element j = B[k][j], same packing.
- a_edge  output  N*DATA_WIDTH  to the left-edge PE "a" inputs; element i drives row i.
- b_edge  output  N*DATA_WIDTH  to the top-edge PE "b" inputs; element j drives column j.
- busy  output  1  high in STREAM and DRAIN.
- done  output  1  one-cycle pulse: array results are complete.

Behaviour:
- Reset (async, rst=0):
  - a_edge=0, b_edge=0, busy=0, done=0, in_ready=1.
  - State=LOAD, beat count=0, stream counter=0, buffers cleared.
  - Reset during any state aborts the operation; no partial data is emitted afterward.
- States: LOAD -> STREAM -> DRAIN -> LOAD. done pulses on the DRAIN->LOAD edge.
- LOAD:
  - in_ready=1.
  - A beat is accepted only when in_valid && in_ready at the clock edge; slice k = beat count stores A[*][k] and B[k][*].
  - Gaps in in_valid are allowed; only handshake beats count.
  - After beat N-1 is accepted, go to STREAM with t=0.
  - a_edge and b_edge hold 0 throughout LOAD.
- STREAM, t = 0 .. 2N-2:
  - in_ready=0, busy=1; in_valid is ignored.
  - a_edge element i = A[i][t-i] if 0 <= t-i < N, else 0.
  - b_edge element j = B[t-j][j] if 0 <= t-j < N, else 0.
  - Outputs are registers; the values for cycle t are present throughout the t-th cycle in STREAM. The first STREAM cycle (t=0) is the cycle immediately after the last LOAD handshake edge.
- DRAIN, t = 2N-1 .. 3N-3:
  - Edges held at 0, busy=1; lets operands propagate N-1 hops to PE(N-1,N-1).
- Completion:
  - At the clock edge ending t=3N-3, go to LOAD.
  - done=1 for exactly the one cycle following that edge (the first LOAD cycle); in_ready=1 in the same cycle.
- Total latency: last accepted beat -> done asserted = 3N-1 clock edges (t=0..3N-3, then the pulse cycle).
- Arithmetic: none. Values pass through bit-exact, sign preserved, with no extension or truncation.
- Back-to-back operation:
  - A new operand set may begin loading during the done cycle.
  - PE accumulators have no clear other than rst, so the system must reset the array between matrices. The feeder does not generate that reset.
- Simultaneous in_valid during STREAM/DRAIN: ignored; in_ready stays low, so no beat is lost or counted.

Test Plan:
- Reset: hold rst=0 with in_valid=1 and random data -> a_edge=b_edge=0, in_ready=1, busy=0, done=0. After release, outputs stay 0 until 4 beats are accepted.
- Skew check (N=4, A[i][k]=4i+k+1, B[k][j]=-(4k+j+1), 4 consecutive beats):
  - t=0: a_edge={0,0,0,1} (element 3..0), b_edge element0=-1, others 0.
  - t=3: a_edge={13,10,7,4}.
  - t=6: a_edge element3=16, others 0; b_edge element3=-16.
  - t=7..9: all zero.
- Completion: same load -> busy=1 for exactly 10 cycles; done high for exactly 1 cycle after t=9; in_ready=1 in that same cycle; done never re-asserts without a new load.
- Backpressure: in_valid pattern 1,0,0,1,1,0,1 -> exactly 4 beats stored in handshake order. in_valid=1 held during STREAM -> in_ready=0, and a subsequent load starts at beat 0.
- Mid-operation reset: assert rst=0 at STREAM t=4 -> edges go 0 immediately (async). After release, state=LOAD, in_ready=1, and no operand from the aborted set appears on any edge.
- Integration with a 4x4 PE grid (DATA_WIDTH=10, data from the skew check) -> after done, C[0][0]=-90 and C[3][3]=-(13*4+14*8+15*12+16*16)=-600; all 16 results match A*B.
